// File: rtl/phy_pkg.sv
// Shared PHY definitions: comma byte, receive FSM encoding and lane count.
// Used by both the transmit serializer and the receive deframer.
package phy_pkg;

  localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
  localparam int         NUM_LANES     = 4;
  localparam int         LANE_W        = $clog2(NUM_LANES);

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ALIGN  = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

  function automatic logic is_comma(input logic [7:0] b, input logic [7:0] comma);
    return (b == comma);
  endfunction

endpackage

// File: rtl/rx_byte_aligner.sv
// Serial-to-byte aligner: hunts bit-by-bit for the comma, confirms a run of
// byte-aligned commas, then emits one byte per 8 clocks once active.
module rx_byte_aligner
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         SYNC_COUNT = 4
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in,
  output logic       byte_done,
  output logic [7:0] rx_byte,
  output logic       active
);

  localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

  rx_state_e  state_r;
  logic [7:0] sr_r;
  logic [2:0] bitcnt_r;
  logic [3:0] comma_cnt_r;
  logic       active_r;

  logic [7:0] nb_s;
  logic       nb_comma_s;
  logic       byte_end_s;

  assign nb_s       = {sr_r[6:0], data_in};
  assign nb_comma_s = is_comma(nb_s, COMMA);
  assign byte_end_s = (bitcnt_r == 3'd7);

  // byte_done is taken straight from the LSB edge so the lane registers
  // in the parent capture the byte on that same edge.
  assign byte_done = (state_r == ACTIVE) && byte_end_s;
  assign rx_byte   = nb_s;
  assign active    = active_r;

  // Shift register plus HUNT/ALIGN/ACTIVE alignment state machine.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_r     <= HUNT;
      sr_r        <= 8'h00;
      bitcnt_r    <= 3'd0;
      comma_cnt_r <= 4'd0;
      active_r    <= 1'b0;
    end else begin
      sr_r <= nb_s;
      case (state_r)
        HUNT: begin
          bitcnt_r <= 3'd0;
          active_r <= 1'b0;
          if (nb_comma_s) begin
            comma_cnt_r <= 4'd1;
            if (SYNC_TARGET == 4'd1) begin
              state_r  <= ACTIVE;
              active_r <= 1'b1;
            end else begin
              state_r <= ALIGN;
            end
          end else begin
            comma_cnt_r <= 4'd0;
          end
        end
        ALIGN: begin
          bitcnt_r <= bitcnt_r + 3'd1;
          if (byte_end_s) begin
            if (nb_comma_s) begin
              comma_cnt_r <= comma_cnt_r + 4'd1;
              if ((comma_cnt_r + 4'd1) == SYNC_TARGET) begin
                state_r  <= ACTIVE;
                active_r <= 1'b1;
              end else begin
                state_r <= ALIGN;
              end
            end else begin
              // Misaligned byte: drop back and restart the bit hunt next cycle.
              state_r     <= HUNT;
              comma_cnt_r <= 4'd0;
              bitcnt_r    <= 3'd0;
            end
          end else begin
            state_r <= ALIGN;
          end
        end
        ACTIVE: begin
          bitcnt_r <= bitcnt_r + 3'd1;
          active_r <= 1'b1;
        end
        default: begin
          state_r     <= HUNT;
          bitcnt_r    <= 3'd0;
          comma_cnt_r <= 4'd0;
          active_r    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/phy_rx_deframer.sv
// Receive deframer top: distributes aligned bytes round-robin onto four lanes
// with per-lane valid flags and tracks comma-only idle periods.
module phy_rx_deframer
  import phy_pkg::*;
#(
  parameter logic [7:0] COMMA      = COMMA_DEFAULT,
  parameter int         SYNC_COUNT = 4,
  parameter int         IDLE_COUNT = 8
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic                 data_in,
  output logic [7:0]           data_out_0,
  output logic [7:0]           data_out_1,
  output logic [7:0]           data_out_2,
  output logic [7:0]           data_out_3,
  output logic                 valid_out_0,
  output logic                 valid_out_1,
  output logic                 valid_out_2,
  output logic                 valid_out_3,
  output logic [NUM_LANES-1:0] lane_strobe,
  output logic                 active,
  output logic                 idle
);

  localparam logic [7:0] IDLE_TARGET = 8'(IDLE_COUNT);

  logic             byte_done_s;
  logic [7:0]       rx_byte_s;
  logic             byte_comma_s;
  logic [7:0]       idle_cnt_next_s;

  logic [LANE_W-1:0]    lane_ptr_r;
  logic [7:0]           data_r [NUM_LANES];
  logic [NUM_LANES-1:0] valid_r;
  logic [NUM_LANES-1:0] strobe_r;
  logic [7:0]           idle_cnt_r;
  logic                 idle_r;

  rx_byte_aligner #(
    .COMMA      (COMMA),
    .SYNC_COUNT (SYNC_COUNT)
  ) u_aligner (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .byte_done (byte_done_s),
    .rx_byte   (rx_byte_s),
    .active    (active)
  );

  assign byte_comma_s = is_comma(rx_byte_s, COMMA);

  // Next idle count: saturate on commas, clear on any data byte.
  always_comb begin
    idle_cnt_next_s = idle_cnt_r;
    if (byte_done_s) begin
      if (!byte_comma_s) begin
        idle_cnt_next_s = 8'd0;
      end else if (idle_cnt_r != IDLE_TARGET) begin
        idle_cnt_next_s = idle_cnt_r + 8'd1;
      end else begin
        idle_cnt_next_s = idle_cnt_r;
      end
    end else begin
      idle_cnt_next_s = idle_cnt_r;
    end
  end

  // Lane registers, lane pointer, strobes and idle status.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      lane_ptr_r <= '0;
      for (int i = 0; i < NUM_LANES; i++) begin
        data_r[i] <= 8'h00;
      end
      valid_r    <= '0;
      strobe_r   <= '0;
      idle_cnt_r <= 8'd0;
      idle_r     <= 1'b0;
    end else begin
      strobe_r   <= '0;
      idle_cnt_r <= idle_cnt_next_s;
      idle_r     <= (idle_cnt_next_s == IDLE_TARGET);
      if (byte_done_s) begin
        strobe_r[lane_ptr_r] <= 1'b1;
        lane_ptr_r           <= lane_ptr_r + LANE_W'(1);
        if (byte_comma_s) begin
          // Filler slot: keep the last real byte, only drop the valid flag.
          valid_r[lane_ptr_r] <= 1'b0;
        end else begin
          valid_r[lane_ptr_r] <= 1'b1;
          data_r[lane_ptr_r]  <= rx_byte_s;
        end
      end else begin
        lane_ptr_r <= lane_ptr_r;
      end
    end
  end

  assign data_out_0  = data_r[0];
  assign data_out_1  = data_r[1];
  assign data_out_2  = data_r[2];
  assign data_out_3  = data_r[3];
  assign valid_out_0 = valid_r[0];
  assign valid_out_1 = valid_r[1];
  assign valid_out_2 = valid_r[2];
  assign valid_out_3 = valid_r[3];
  assign lane_strobe = strobe_r;
  assign idle        = idle_r;

endmodule

// File: tb/tb_phy_rx_deframer.sv
// Directed bench for phy_rx_deframer: alignment, lane distribution, idle and
// reset behaviour with hand-computed expectations.
module tb_phy_rx_deframer;

  logic       clk_32f = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [7:0] data_out_0, data_out_1, data_out_2, data_out_3;
  logic       valid_out_0, valid_out_1, valid_out_2, valid_out_3;
  logic [3:0] lane_strobe;
  logic       active, idle;

  int checks = 0;
  int errors = 0;
  int strobe_pulses = 0;
  int strobe_bad = 0;

  phy_rx_deframer dut (
    .clk_32f     (clk_32f),
    .reset       (reset),
    .data_in     (data_in),
    .data_out_0  (data_out_0),
    .data_out_1  (data_out_1),
    .data_out_2  (data_out_2),
    .data_out_3  (data_out_3),
    .valid_out_0 (valid_out_0),
    .valid_out_1 (valid_out_1),
    .valid_out_2 (valid_out_2),
    .valid_out_3 (valid_out_3),
    .lane_strobe (lane_strobe),
    .active      (active),
    .idle        (idle)
  );

  always #5 clk_32f = ~clk_32f;

  // Strobe monitor: count pulses, flag non-one-hot or strobes while inactive.
  always @(negedge clk_32f) begin
    if (!reset) begin
      if (lane_strobe != 4'b0000) strobe_pulses++;
      if ($countones(lane_strobe) > 1) strobe_bad++;
      if ((lane_strobe != 4'b0000) && !active) strobe_bad++;
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    data_in = b;
    @(posedge clk_32f);
    #1;
  endtask

  task automatic send_range(input logic [7:0] b, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) send_bit(b[i]);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_range(b, 7, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_d0"}, data_out_0, 8'h00);
    check({tag, "_d1"}, data_out_1, 8'h00);
    check({tag, "_d2"}, data_out_2, 8'h00);
    check({tag, "_d3"}, data_out_3, 8'h00);
    check({tag, "_valid"}, {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, 8'h00);
    check({tag, "_strobe"}, {4'h0, lane_strobe}, 8'h00);
    check({tag, "_active"}, {7'h0, active}, 8'h00);
    check({tag, "_idle"}, {7'h0, idle}, 8'h00);
  endtask

  initial begin
    // Power-on reset.
    reset = 1'b1;
    @(posedge clk_32f); #1;
    @(posedge clk_32f); #1;
    check_all_zero("por");
    reset = 1'b0;

    // Bit-offset alignment: 3 stray bits, then four commas.
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_byte(8'hBC);
    check("align_c1", {7'h0, active}, 8'h00);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("align_c3", {7'h0, active}, 8'h00);
    send_range(8'hBC, 7, 1);
    check("align_c4_pre", {7'h0, active}, 8'h00);
    send_range(8'hBC, 0, 0);
    check("align_c4", {7'h0, active}, 8'h01);
    check("align_strobe", {4'h0, lane_strobe}, 8'h00);

    send_byte(8'h11);
    check("l0_data", data_out_0, 8'h11);
    check("l0_strobe", {4'h0, lane_strobe}, 8'h01);
    send_bit(1'b0);
    check("l0_strobe_gap", {4'h0, lane_strobe}, 8'h00);
    send_range(8'h22, 6, 0);
    check("l1_data", data_out_1, 8'h22);
    check("l1_strobe", {4'h0, lane_strobe}, 8'h02);
    send_byte(8'h33);
    check("l2_strobe", {4'h0, lane_strobe}, 8'h04);
    send_byte(8'h44);
    check("l3_strobe", {4'h0, lane_strobe}, 8'h08);
    check("lanes_d2", data_out_2, 8'h33);
    check("lanes_d3", data_out_3, 8'h44);
    check("lanes_valid", {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, 8'h0F);

    // Mixed valid: commas clear valid but keep the previous data.
    send_byte(8'hA1);
    send_byte(8'hBC);
    send_byte(8'hA3);
    send_byte(8'hBC);
    check("mix_valid", {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, 8'h05);
    check("mix_d0", data_out_0, 8'hA1);
    check("mix_d1", data_out_1, 8'h22);
    check("mix_d2", data_out_2, 8'hA3);
    check("mix_d3", data_out_3, 8'h44);

    // Idle: one data byte resets the count, then eight commas.
    send_byte(8'h55);
    for (int i = 0; i < 7; i++) send_byte(8'hBC);
    check("idle_7th", {7'h0, idle}, 8'h00);
    send_byte(8'hBC);
    check("idle_8th", {7'h0, idle}, 8'h01);
    check("idle_valid", {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, 8'h00);
    check("idle_d0_hold", data_out_0, 8'h55);
    send_byte(8'h07);
    check("idle_clear", {7'h0, idle}, 8'h00);
    check("idle_d1", data_out_1, 8'h07);
    check("idle_strobe", {4'h0, lane_strobe}, 8'h02);

    // Lane wrap: pad to lane 0, then 0x01..0x0C.
    send_byte(8'h66);
    send_byte(8'h77);
    for (int i = 1; i <= 12; i++) begin
      send_byte(8'(i));
      if ((i % 4) == 1) check("wrap_d0", data_out_0, 8'(i));
    end
    check("wrap_d0_end", data_out_0, 8'h09);
    check("wrap_d1_end", data_out_1, 8'h0A);
    check("wrap_d2_end", data_out_2, 8'h0B);
    check("wrap_d3_end", data_out_3, 8'h0C);
    check("wrap_valid", {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, 8'h0F);

    // Reset mid-byte while active.
    send_range(8'hF0, 7, 4);
    reset = 1'b1;
    @(posedge clk_32f); #1;
    check_all_zero("mid_rst");
    @(posedge clk_32f); #1;
    reset = 1'b0;

    // False start after reset, then a clean four-comma re-sync.
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'h5A);
    check("false_5a", {7'h0, active}, 8'h00);
    send_byte(8'hBC);
    send_byte(8'hBC);
    send_byte(8'hBC);
    check("resync_c3", {7'h0, active}, 8'h00);
    send_byte(8'hBC);
    check("resync_c4", {7'h0, active}, 8'h01);
    send_byte(8'h3C);
    check("resync_d0", data_out_0, 8'h3C);
    check("resync_valid", {4'h0, valid_out_3, valid_out_2, valid_out_1, valid_out_0}, 8'h01);
    check("resync_strobe", {4'h0, lane_strobe}, 8'h01);

    @(posedge clk_32f); #1;
    check("strobe_pulses", 8'(strobe_pulses), 8'd33);
    check("strobe_bad", 8'(strobe_bad), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phy_rx_deframer.md
# phy_rx_deframer

Receive-side counterpart of the PHY transmit path: takes the single serial bit stream produced by the transmit serializer and recovers byte alignment by hunting for the comma byte. It recovers the four interleaved 8-bit lanes with per-lane valid flags and raises `active` and `idle` status for the link layer. It sits at the `phy_rx` input, runs entirely in the `clk_32f` domain, and drives the lane outputs consumed by the receive-side demultiplexing and recirculation logic.

## Interface
- `COMMA`, 8'hBC — sync/filler byte; the transmitter sends it whenever a lane slot carries no valid data.
- `SYNC_COUNT`, 4 — number of consecutive byte-aligned commas required before `active` asserts (range 1–15).
- `IDLE_COUNT`, 8 — number of consecutive comma bytes while active that asserts `idle` (range 1–255).
- `clk_32f` input 1 — bit clock; one serial bit per rising edge.
- `reset` input 1 — synchronous, active-high.
- `data_in` input 1 — serial stream, MSB of each byte first.
- `data_out_0` … `data_out_3` output 8 each — last valid byte received for lane n.
- `valid_out_0` … `valid_out_3` output 1 each — lane n's most recent slot carried data (non-comma).
- `lane_strobe` output 4 — one-cycle pulse; bit n is high on the cycle lane n's outputs are updated.
- `active` output 1 — byte alignment achieved.
- `idle` output 1 — link active but carrying only commas.

## Operation
- Shift register `sr[7:0]` ← `{sr[6:0], data_in}` every cycle in every state. Let `nb = {sr[6:0], data_in}`.
- States: HUNT, ALIGN, ACTIVE.
- HUNT: bit-granular search. If `nb == COMMA`, go to ALIGN with `bitcnt=0` and `comma_cnt=1`. With SYNC_COUNT=1, go directly to ACTIVE instead.
- ALIGN: `bitcnt` increments 0..7 and wraps. On `bitcnt==7`, a byte completes:
  - `nb==COMMA`: `comma_cnt++`. If the new count equals SYNC_COUNT, go to ACTIVE.
  - otherwise: return to HUNT and clear `comma_cnt`.
- ACTIVE: `bitcnt` keeps free-running modulo 8. On `bitcnt==7`, byte `nb` belongs to lane `lane_ptr`:
  - Non-comma byte: `data_out_n ← nb`, `valid_out_n ← 1`.
  - Comma byte: `valid_out_n ← 0`, `data_out_n` holds its previous value.
  - `lane_strobe[lane_ptr]` pulses; `lane_ptr` advances 0→1→2→3→0.
- Lane ordering: `lane_ptr` is 0 on entry to ACTIVE, so the first byte after the aligning commas is lane 0. This matches the transmit mux, which starts on lane 0 after reset.
- ACTIVE is left only by `reset`. The design has no loss-of-sync detection; this is a deliberate decision.
- `idle_cnt` (8-bit, saturating at IDLE_COUNT): increments on each comma byte in ACTIVE and clears on any non-comma byte. `idle` = 1 while `idle_cnt == IDLE_COUNT`.
- Data bytes equal to COMMA cannot be distinguished from filler. Upstream guarantees that data never equals COMMA.

## Timing
- Reset: state HUNT, and all counters, `sr`, `data_out_*`, `valid_out_*`, `lane_strobe`, `active` and `idle` are 0 after the reset edge. A reset asserted mid-byte or mid-alignment discards the partial byte.
- All outputs are registered and update on the same edge that samples bit 7 (LSB) of the byte. Latency from the LSB on `data_in` to the lane output is one edge.
- `active` rises on the edge that completes the SYNC_COUNT-th aligned comma. The earliest `active` is 8·SYNC_COUNT cycles after the first comma's MSB (32 with the default).
- `lane_strobe` is high for exactly one cycle per 8 cycles in ACTIVE and is one-hot. `lane_strobe` is never high outside ACTIVE.
- `idle` rises on the edge that completes the IDLE_COUNT-th consecutive comma. `idle` falls on the edge that completes the next non-comma byte.
- A non-comma byte during ALIGN on the same edge as a potential HUNT match: the ALIGN→HUNT transition wins. Bit hunting resumes on the next cycle.

## Structure
- Shared package `phy_pkg`: `COMMA` default (8'hBC), state encoding `{HUNT, ALIGN, ACTIVE}`, and `NUM_LANES = 4`. The transmit serializer uses the same COMMA constant.
- Sub-module `rx_byte_aligner`: contains `sr`, `bitcnt`, the comma compare and the HUNT/ALIGN/ACTIVE FSM. It outputs `byte_done`, `byte[7:0]` and `active`.
- The top level holds `lane_ptr`, the lane registers and the idle counter.
- Expected size is about 200 lines total.

## Test plan
- Reset mid-stream: drive `reset=1` for 2 cycles during ACTIVE -> all outputs 0 and state HUNT on the next edge; re-sync needs 4 fresh commas.
- Bit-offset alignment: 3 random bits, then 4×0xBC, then 0x11, 0x22, 0x33, 0x44 -> `active`=1 on the 4th comma's LSB edge; lanes 0..3 = 11/22/33/44 with valid=1; `lane_strobe` sequence 0001, 0010, 0100, 1000 spaced 8 cycles apart.
- False start: 0xBC, 0xBC, 0x5A, then 4×0xBC -> `active` stays 0 through the 0x5A and rises only after the later 4 commas.
- Mixed valid: while active, send 0xA1, 0xBC, 0xA3, 0xBC -> valid_out_0..3 = 1,0,1,0; data_out_1 and data_out_3 retain their prior values.
- Idle: while active, send 8 commas -> `idle` rises on the 8th comma's LSB edge; a following 0x07 clears `idle` on its LSB edge and the lane pointer continues wrapping correctly.
- Lane wrap: stream 12 data bytes 0x01..0x0C -> lane 0 is updated with 01, 05 and 09, and it holds 09 at the end.
